// File: rtl/gru_dot_mac.sv
// Sequential fixed-point dot product (bias + sum x*w) with round-half-up and
// saturation to a Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH word feeding the tanh stage.
module gru_dot_mac #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int N_TERMS     = 24,
  parameter int ACC_WIDTH   = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] w,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are
  // both high; valid, once raised, holds its data stable until that edge, and
  // ready never depends combinationally on the partner's valid.

  localparam int CNT_W = (N_TERMS < 2) ? 1 : $clog2(N_TERMS + 1);

  localparam logic signed [ACC_WIDTH-1:0] MAX_Y =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_Y =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] HALF =
    ACC_WIDTH'(1) << (FRACT_WIDTH - 1);

  if (ACC_WIDTH < 2*DATA_WIDTH + $clog2(N_TERMS) + 1) begin : g_acc_width_check
    $error("gru_dot_mac: ACC_WIDTH too small for N_TERMS full-precision products");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_FINAL = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                        state;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic [CNT_W-1:0]              cnt;
  logic                          accept;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   bias_sh;
  logic signed [ACC_WIDTH-1:0]   rnd;
  logic signed [ACC_WIDTH-1:0]   r;
  logic [DATA_WIDTH-1:0]         y_sat;

  assign accept    = in_valid & in_ready;
  assign prod      = $signed(x) * $signed(w);
  assign prod_ext  = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  // Bias is Q8.8; align it to the Q16.16 product scale.
  assign bias_sh   = {{(ACC_WIDTH-DATA_WIDTH-FRACT_WIDTH){bias[DATA_WIDTH-1]}},
                      bias, {FRACT_WIDTH{1'b0}}};
  assign rnd       = acc + HALF;
  assign r         = rnd >>> FRACT_WIDTH;
  assign state_dbg = state;

  always_comb begin
    y_sat = r[DATA_WIDTH-1:0];
    if (r > MAX_Y)      y_sat = MAX_Y[DATA_WIDTH-1:0];
    else if (r < MIN_Y) y_sat = MIN_Y[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc  <= bias_sh + prod_ext;
            cnt  <= CNT_W'(1);
            busy <= 1'b1;
            if (N_TERMS == 1) begin
              state    <= S_FINAL;
              in_ready <= 1'b0;
            end else begin
              state <= S_ACC;
            end
          end
        end
        S_ACC: begin
          if (accept) begin
            acc <= acc + prod_ext;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(N_TERMS - 1)) begin
              state    <= S_FINAL;
              in_ready <= 1'b0;
            end
          end
        end
        S_FINAL: begin
          y         <= y_sat;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          // in_ready returns only after the handshake edge: no same-cycle restart.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gru_dot_mac.sv
// Directed bench for gru_dot_mac: a 4-term and a 1-term instance driven with
// hand-computed vectors, plus a handshake scoreboard on the 4-term instance.
module tb_gru_dot_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_ready;
  logic [15:0] x, w, bias;
  logic        in_valid4, in_valid1;
  logic        in_ready4, out_valid4, busy4;
  logic        in_ready1, out_valid1, busy1;
  logic [15:0] y4, y1;
  logic [1:0]  st4, st1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  // clock / reset
  always #5 clk = ~clk;

  gru_dot_mac #(.DATA_WIDTH(16), .FRACT_WIDTH(8), .N_TERMS(4), .ACC_WIDTH(40)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .x(x), .w(w), .bias(bias), .out_valid(out_valid4), .out_ready(out_ready),
    .y(y4), .busy(busy4), .state_dbg(st4)
  );

  gru_dot_mac #(.DATA_WIDTH(16), .FRACT_WIDTH(8), .N_TERMS(1), .ACC_WIDTH(40)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .x(x), .w(w), .bias(bias), .out_valid(out_valid1), .out_ready(out_ready),
    .y(y1), .busy(busy1), .state_dbg(st1)
  );

  // Inputs only change at posedge+1, so the negedge sees what the next edge will.
  always @(negedge clk) begin
    if (!rst && out_valid4 && out_ready) got_q.push_back(y4);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int sel, input logic [15:0] xv, input logic [15:0] wv,
                      input logic [15:0] bv);
    int guard;
    guard = 0;
    x = xv; w = wv; bias = bv;
    if (sel == 4) in_valid4 = 1'b1;
    else          in_valid1 = 1'b1;
    while (((sel == 4) ? !in_ready4 : !in_ready1) && guard < 50) begin
      tick();
      guard++;
    end
    check("push_wait", 32'(guard < 50), 32'd1);
    tick();
    in_valid4 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  task automatic wait_out(input int sel);
    int guard;
    guard = 0;
    while (((sel == 4) ? !out_valid4 : !out_valid1) && guard < 50) begin
      tick();
      guard++;
    end
    check("out_wait", 32'(guard < 50), 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run1(input string tag, input logic [15:0] xv, input logic [15:0] wv,
                      input logic [15:0] exp_y);
    push(1, xv, wv, 16'h0000);
    check({tag, "_final_no_valid"}, 32'(out_valid1), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(out_valid1), 32'd1);
    check({tag, "_y"}, 32'(y1), 32'(exp_y));
    handshake();
    check({tag, "_ready_back"}, 32'(in_ready1), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid4 = 1'b0; in_valid1 = 1'b0; out_ready = 1'b0;
    x = '0; w = '0; bias = '0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready4), 32'd1);
    check("rst_out_valid", 32'(out_valid4), 32'd0);
    check("rst_y", 32'(y4), 32'd0);
    check("rst_busy", 32'(busy4), 32'd0);
    rst = 1'b0;
    tick();

    // 4 x (1.0 * 0.5) = 2.0, with latency check
    for (int i = 0; i < 4; i++) push(4, 16'h0100, 16'h0080, 16'h0000);
    check("lat_final_state", 32'(st4), 32'd2);
    check("lat_no_valid_yet", 32'(out_valid4), 32'd0);
    check("lat_in_ready_low", 32'(in_ready4), 32'd0);
    check("lat_busy", 32'(busy4), 32'd1);
    tick();
    check("lat_valid", 32'(out_valid4), 32'd1);
    check("basic_y", 32'(y4), 32'h0200);
    exp_q.push_back(16'h0200);
    handshake();
    check("basic_ready_back", 32'(in_ready4), 32'd1);
    check("basic_valid_drop", 32'(out_valid4), 32'd0);
    check("basic_busy_drop", 32'(busy4), 32'd0);

    // positive and negative saturation
    for (int i = 0; i < 4; i++) push(4, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    wait_out(4);
    check("sat_pos_y", 32'(y4), 32'h7FFF);
    exp_q.push_back(16'h7FFF);
    handshake();
    for (int i = 0; i < 4; i++) push(4, 16'h7FFF, 16'h8000, 16'h8000);
    wait_out(4);
    check("sat_neg_y", 32'(y4), 32'h8000);
    exp_q.push_back(16'h8000);
    handshake();

    // single-term rounding boundaries
    run1("round_half_up", 16'h0001, 16'h0080, 16'h0001);
    run1("round_neg_half", 16'hFFFF, 16'h0080, 16'h0000);
    run1("round_below_half", 16'h0001, 16'h007F, 16'h0000);

    // random in_valid gaps; bias only taken from the first pair
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) begin
        x = 16'h7777;
        tick();
      end
      push(4, 16'h0100, 16'h0100, (i == 0) ? 16'hFF00 : 16'h1234);
    end
    wait_out(4);
    in_valid4 = 1'b1; x = 16'h7FFF; w = 16'h7FFF;
    for (int i = 0; i < 5; i++) begin
      check("hold_y", 32'(y4), 32'h0300);
      check("hold_valid", 32'(out_valid4), 32'd1);
      check("hold_in_ready", 32'(in_ready4), 32'd0);
      tick();
    end
    in_valid4 = 1'b0;
    exp_q.push_back(16'h0300);
    handshake();
    check("hold_ready_back", 32'(in_ready4), 32'd1);
    check("hold_y_kept", 32'(y4), 32'h0300);
    check("hold_valid_drop", 32'(out_valid4), 32'd0);

    // reset mid-sum discards the partial accumulation
    push(4, 16'h0100, 16'h0100, 16'h0500);
    push(4, 16'h0100, 16'h0100, 16'h0500);
    rst = 1'b1;
    #2;
    check("midrst_in_ready", 32'(in_ready4), 32'd1);
    check("midrst_out_valid", 32'(out_valid4), 32'd0);
    check("midrst_y", 32'(y4), 32'd0);
    check("midrst_busy", 32'(busy4), 32'd0);
    check("midrst_state", 32'(st4), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    push(4, 16'h0000, 16'h0000, 16'h0100);
    for (int i = 0; i < 3; i++) push(4, 16'h0000, 16'h0000, 16'h0000);
    wait_out(4);
    check("after_rst_y", 32'(y4), 32'h0100);
    exp_q.push_back(16'h0100);
    handshake();

    // two back-to-back dot products with out_ready held high
    out_ready = 1'b1;
    push(4, 16'h0100, 16'h0040, 16'h0200);
    for (int i = 0; i < 3; i++) push(4, 16'h0100, 16'h0040, 16'h7FFF);
    push(4, 16'hFF00, 16'h0080, 16'hFE00);
    for (int i = 0; i < 3; i++) push(4, 16'hFF00, 16'h0080, 16'h0100);
    repeat (6) tick();
    out_ready = 1'b0;
    exp_q.push_back(16'h0300);
    exp_q.push_back(16'hFC00);
    check("b2b_final_y", 32'(y4), 32'hFC00);
    tick();

    // scoreboard
    check("sb_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("sb_item%0d", i), 32'(got_q[i]), 32'(exp_q[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
